// File: rtl/type1_dmmrx_wr.sv
// -----------------------------------------------------------------------------
// type1_dmmrx_wr
//   Receive-side frame writer for the TYPE1 receive data memory
//   (1K x 18 TPRAM organised as 16 channels x 64 words).
//   Parses a header word, buffers up to MAX_LEN payload words and checks a
//   16-bit additive checksum. A good frame is written into its channel's
//   64-word region as a burst; a bad frame is discarded without touching
//   memory. Saturating counters track good and dropped frames.
//
// Frame on the rx stream:
//   header (rx_sof=1): [17:16] ex_box, [15:12] chn, [11:6] LEN, [5:0] unused
//   LEN payload words
//   checksum (rx_eof=1): [15:0] = sum of payload[15:0] mod 2^16, [17:16] unused
//
// Handshake: a word is transferred on a rising clk_100m edge where
//   rx_vld & rx_rdy is 1. The source must hold rx_vld/rx_sof/rx_eof/rx_data
//   stable until that transfer; rx_rdy does not depend on rx_vld.
//
// Ports:
//   clk_100m     in   system clock
//   rst_100m     in   asynchronous reset, active-low
//   rx_vld       in   input word valid
//   rx_sof       in   first word of frame (header)
//   rx_eof       in   last word of frame (checksum)
//   rx_data      in   18-bit input word
//   rx_rdy       out  ready to accept an input word (IDLE / PAYLOAD only)
//   ex_box_num   out  expansion box of the frame being committed
//   wr_en        out  memory write strobe, one word per cycle
//   wr_addr      out  memory write address {chn, offset}
//   wr_data      out  memory write data
//   frm_done     out  1-cycle pulse: frame committed
//   frm_err      out  1-cycle pulse: frame dropped
//   err_code     out  cause of last drop: 0 length, 1 sof/eof framing, 2 checksum
//   frm_ok_cnt   out  good frames, saturating
//   frm_err_cnt  out  dropped frames, saturating
//   dbg_state    out  current FSM state (0 IDLE,1 PAYLOAD,2 CHECK,3 COMMIT,4 DROP)
// -----------------------------------------------------------------------------
module type1_dmmrx_wr #(
  parameter logic [5:0] MAX_LEN = 6'd63,
  parameter int         CNT_W   = 16
) (
  input  logic             clk_100m,
  input  logic             rst_100m,
  input  logic             rx_vld,
  input  logic             rx_sof,
  input  logic             rx_eof,
  input  logic [17:0]      rx_data,
  output logic             rx_rdy,
  output logic [1:0]       ex_box_num,
  output logic             wr_en,
  output logic [9:0]       wr_addr,
  output logic [17:0]      wr_data,
  output logic             frm_done,
  output logic             frm_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frm_ok_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_CHECK   = 3'd2,
    S_COMMIT  = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_LEN  = 2'd0;
  localparam logic [1:0] ERR_FRM  = 2'd1;
  localparam logic [1:0] ERR_CKS  = 2'd2;

  state_t state, state_nx;

  // Latched header and payload bookkeeping
  logic [1:0]  hdr_ex;
  logic [3:0]  hdr_chn;
  logic [5:0]  hdr_len;
  logic [15:0] sum;
  logic [15:0] cks;
  logic [5:0]  idx;      // next payload slot; equals hdr_len when checksum is due
  logic [5:0]  wr_cnt;   // next commit offset while in COMMIT

  // Payload buffer. 64 entries so any 6-bit index is in range; the top entry
  // is never written because idx < LEN <= 63 whenever a word is stored.
  logic [17:0] buf_mem [0:63];

  logic        acc;
  logic        len_bad;
  logic        buf_we;
  logic [1:0]  drop_code;
  logic [5:0]  rd_off;

  // Next values of the registered outputs
  logic             wr_en_d;
  logic [9:0]       wr_addr_d;
  logic [17:0]      wr_data_d;
  logic [1:0]       ex_box_d;
  logic             frm_done_d;
  logic             frm_err_d;
  logic [1:0]       err_code_d;
  logic [CNT_W-1:0] ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;

  assign rx_rdy    = (state == S_IDLE) || (state == S_PAYLOAD);
  assign acc       = rx_vld & rx_rdy;
  assign len_bad   = (rx_data[11:6] == 6'd0) || (rx_data[11:6] > MAX_LEN);
  assign dbg_state = state;

  // Payload words are stored only for slots before the checksum position and
  // only when the word is a plain data word (no sof/eof).
  assign buf_we = (state == S_PAYLOAD) && acc && !rx_sof && !rx_eof &&
                  (idx != hdr_len);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100m or negedge rst_100m) begin
    if (!rst_100m) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and drop cause
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    drop_code = ERR_LEN;
    case (state)
      S_IDLE: begin
        // Non-sof words are ignored here; a length fault outranks sof+eof.
        if (acc && rx_sof) begin
          if (len_bad) begin
            state_nx  = S_DROP;
            drop_code = ERR_LEN;
          end else if (rx_eof) begin
            state_nx  = S_DROP;
            drop_code = ERR_FRM;
          end else begin
            state_nx = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (acc) begin
          if (rx_sof) begin
            state_nx  = S_DROP;
            drop_code = ERR_FRM;
          end else if (idx == hdr_len) begin
            if (rx_eof) begin
              state_nx = S_CHECK;
            end else begin
              state_nx  = S_DROP;
              drop_code = ERR_FRM;
            end
          end else if (rx_eof) begin
            state_nx  = S_DROP;
            drop_code = ERR_FRM;
          end
        end
      end
      S_CHECK: begin
        if (sum == cks) begin
          state_nx = S_COMMIT;
        end else begin
          state_nx  = S_DROP;
          drop_code = ERR_CKS;
        end
      end
      S_COMMIT: begin
        if (wr_cnt == hdr_len) begin
          state_nx = S_IDLE;
        end
      end
      S_DROP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode. Outputs are computed from the transition so they are
  // registered yet line up with the state they belong to: wr_en is high for
  // exactly the LEN COMMIT cycles, frm_err during the DROP cycle, frm_done in
  // the first IDLE cycle after the last write.
  // -------------------------------------------------------------------------
  assign rd_off = (state == S_CHECK) ? 6'd0 : wr_cnt;

  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    ex_box_d   = ex_box_num;
    frm_done_d = 1'b0;
    frm_err_d  = 1'b0;
    err_code_d = err_code;
    ok_cnt_d   = frm_ok_cnt;
    err_cnt_d  = frm_err_cnt;

    if (state_nx == S_COMMIT) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {hdr_chn, rd_off};
      wr_data_d = buf_mem[rd_off];
      ex_box_d  = hdr_ex;
    end

    if ((state == S_COMMIT) && (state_nx == S_IDLE)) begin
      frm_done_d = 1'b1;
      if (frm_ok_cnt != {CNT_W{1'b1}}) begin
        ok_cnt_d = frm_ok_cnt + 1'b1;
      end
    end

    if (state_nx == S_DROP) begin
      frm_err_d  = 1'b1;
      err_code_d = drop_code;
      if (frm_err_cnt != {CNT_W{1'b1}}) begin
        err_cnt_d = frm_err_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100m or negedge rst_100m) begin
    if (!rst_100m) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      ex_box_num  <= '0;
      frm_done    <= 1'b0;
      frm_err     <= 1'b0;
      err_code    <= '0;
      frm_ok_cnt  <= '0;
      frm_err_cnt <= '0;
    end else begin
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      ex_box_num  <= ex_box_d;
      frm_done    <= frm_done_d;
      frm_err     <= frm_err_d;
      err_code    <= err_code_d;
      frm_ok_cnt  <= ok_cnt_d;
      frm_err_cnt <= err_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Header, checksum accumulation and commit offset
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100m or negedge rst_100m) begin
    if (!rst_100m) begin
      hdr_ex  <= '0;
      hdr_chn <= '0;
      hdr_len <= '0;
      sum     <= '0;
      cks     <= '0;
      idx     <= '0;
      wr_cnt  <= '0;
    end else begin
      if ((state == S_IDLE) && acc && rx_sof) begin
        hdr_ex  <= rx_data[17:16];
        hdr_chn <= rx_data[15:12];
        hdr_len <= rx_data[11:6];
        sum     <= '0;
        idx     <= '0;
      end

      if (buf_we) begin
        sum <= sum + rx_data[15:0];
        idx <= idx + 6'd1;
      end

      if ((state == S_PAYLOAD) && (state_nx == S_CHECK)) begin
        cks <= rx_data[15:0];
      end

      // Offset 0 is issued on the CHECK->COMMIT edge, so COMMIT starts at 1.
      if (state == S_CHECK) begin
        wr_cnt <= 6'd1;
      end else if ((state == S_COMMIT) && (state_nx == S_COMMIT)) begin
        wr_cnt <= wr_cnt + 6'd1;
      end
    end
  end

  // Payload buffer: storage only, no reset needed
  always_ff @(posedge clk_100m) begin
    if (buf_we) begin
      buf_mem[idx] <= rx_data;
    end
  end

endmodule
